// File: rtl/mioc_io_pkg.sv
// Shared definitions for the MIOC I/O-write responder: FSM states, port codes
// and the width of the wait and net-reset counters.
package mioc_io_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] PORT_MAP  = 2'b01;
  localparam logic [1:0] PORT_CTRL = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    WAIT,
    COMMIT,
    HOLD
  } state_t;

  // Ports with BA7 set are outside the MIOC window and are ignored.
  function automatic logic port_valid(input logic [1:0] port);
    return (port == PORT_MAP) || (port == PORT_CTRL);
  endfunction

endpackage

// File: rtl/mioc_pulse_gen.sv
// Retriggerable AdamNET reset pulse: a load restarts the full pulse length,
// and the active-low output stays low while the counter is nonzero.
module mioc_pulse_gen
  import mioc_io_pkg::*;
#(
  parameter logic [CNT_W-1:0] PULSE_LEN = 8'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic pulse_n
);

  logic [CNT_W-1:0] count;

  // A reload takes priority so a retrigger always extends the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= PULSE_LEN;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign pulse_n = (count == '0);

endmodule

// File: rtl/mioc_io_resp.sv
// Z80 I/O-write responder for the MIOC control ports: filters the write cycle,
// optionally stretches it with IO_WAIT_N, and commits exactly once per IORQ_N low.
module mioc_io_resp
  import mioc_io_pkg::*;
#(
  parameter int         WAIT_CYCLES = 1,
  parameter int         NET_PULSE   = 8,
  parameter logic [3:0] MAP_RST     = 4'b0000
) (
  input  logic       B_PHI,
  input  logic       RST,
  input  logic       IORQ_N,
  input  logic       N_BWR,
  input  logic       BA7,
  input  logic       BA6,
  input  logic [3:0] BD,
  output logic [3:0] MAP_REG,
  output logic       MAP_WR,
  output logic       SPINDIS_N,
  output logic       NETRST_N,
  output logic       IO_WAIT_N,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] WAIT_LAST =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : CNT_W'(0);

  state_t           state, next_state;
  logic [1:0]       port;
  logic [1:0]       cap_port;
  logic [3:0]       cap_bd;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc;
  logic             same_req;
  logic             commit_map;
  logic             commit_ctrl;
  logic             net_load;

  assign port     = {BA7, BA6};
  assign acc      = !IORQ_N && !N_BWR;
  assign same_req = acc && (port == cap_port) && (BD == cap_bd);

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // IORQ_N is checked before the wait count so an abort on the last wait
  // cycle still wins over the commit.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (acc && port_valid(port)) begin
          next_state = QUAL;
        end
      end
      QUAL: begin
        if (same_req) begin
          next_state = (WAIT_CYCLES == 0) ? COMMIT : WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (IORQ_N) begin
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = COMMIT;
        end
      end
      COMMIT: next_state = HOLD;
      HOLD: begin
        if (IORQ_N) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      cap_port <= PORT_CTRL;
      cap_bd   <= 4'h0;
    end else if (state == IDLE && next_state == QUAL) begin
      cap_port <= port;
      cap_bd   <= BD;
    end
  end

  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign commit_map  = (state == COMMIT) && (cap_port == PORT_MAP);
  assign commit_ctrl = (state == COMMIT) && (cap_port == PORT_CTRL);
  assign net_load    = commit_ctrl && cap_bd[0];

  // MAP_WR is registered so it is high in the same cycle MAP_REG shows the new value.
  always_ff @(posedge B_PHI or posedge RST) begin
    if (RST) begin
      MAP_REG   <= MAP_RST;
      MAP_WR    <= 1'b0;
      SPINDIS_N <= 1'b1;
    end else begin
      MAP_WR <= commit_map;
      if (commit_map) begin
        MAP_REG <= cap_bd;
      end
      if (commit_ctrl) begin
        SPINDIS_N <= !cap_bd[1];
      end
    end
  end

  mioc_pulse_gen #(
    .PULSE_LEN(CNT_W'(NET_PULSE))
  ) u_pulse (
    .clk     (B_PHI),
    .rst     (RST),
    .load    (net_load),
    .pulse_n (NETRST_N)
  );

  assign IO_WAIT_N = (state != WAIT);
  assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_mioc_io_resp.sv
// Bench for mioc_io_resp: two instances (1 and 4 wait cycles) share one bus and
// are checked every cycle against a transaction-level model, plus fixed scenarios.
module tb_mioc_io_resp;

  logic       B_PHI  = 1'b0;
  logic       RST    = 1'b0;
  logic       IORQ_N = 1'b1;
  logic       N_BWR  = 1'b1;
  logic       BA7    = 1'b0;
  logic       BA6    = 1'b0;
  logic [3:0] BD     = 4'h0;

  logic [3:0] map_reg   [2];
  logic       map_wr    [2];
  logic       spindis_n [2];
  logic       netrst_n  [2];
  logic       io_wait_n [2];
  logic       busy      [2];

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  int n_wr   [2] = '{0, 0};
  int n_net  [2] = '{0, 0};
  int n_wait [2] = '{0, 0};

  // Reference model: cycle age since the accepted sample, a committed flag,
  // the captured request and the architectural registers.
  int         m_age  [2] = '{0, 0};
  bit         m_hold [2] = '{0, 0};
  logic [1:0] m_port [2];
  logic [3:0] m_bd   [2];
  logic [3:0] m_map  [2] = '{4'h0, 4'h0};
  bit         m_wr   [2] = '{0, 0};
  bit         m_spin [2] = '{1, 1};
  int         m_net  [2] = '{0, 0};

  mioc_io_resp #(.WAIT_CYCLES(1), .NET_PULSE(8), .MAP_RST(4'b0000)) dut_w1 (
    .B_PHI(B_PHI), .RST(RST), .IORQ_N(IORQ_N), .N_BWR(N_BWR), .BA7(BA7), .BA6(BA6),
    .BD(BD), .MAP_REG(map_reg[0]), .MAP_WR(map_wr[0]), .SPINDIS_N(spindis_n[0]),
    .NETRST_N(netrst_n[0]), .IO_WAIT_N(io_wait_n[0]), .BUSY(busy[0])
  );

  mioc_io_resp #(.WAIT_CYCLES(4), .NET_PULSE(8), .MAP_RST(4'b0000)) dut_w4 (
    .B_PHI(B_PHI), .RST(RST), .IORQ_N(IORQ_N), .N_BWR(N_BWR), .BA7(BA7), .BA6(BA6),
    .BD(BD), .MAP_REG(map_reg[1]), .MAP_WR(map_wr[1]), .SPINDIS_N(spindis_n[1]),
    .NETRST_N(netrst_n[1]), .IO_WAIT_N(io_wait_n[1]), .BUSY(busy[1])
  );

  always #5 B_PHI = ~B_PHI;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // A write is accepted on one sample, confirmed on the next, waits W cycles
  // with IORQ_N low, and commits on the following edge.
  always @(posedge B_PHI) begin : ref_model
    logic       acc;
    logic       commit;
    logic [1:0] p;
    for (int d = 0; d < 2; d++) begin
      p      = {BA7, BA6};
      acc    = !IORQ_N && !N_BWR;
      commit = 1'b0;
      if (RST) begin
        m_age[d]  = 0;
        m_hold[d] = 1'b0;
        m_map[d]  = 4'h0;
        m_wr[d]   = 1'b0;
        m_spin[d] = 1'b1;
        m_net[d]  = 0;
      end else begin
        m_wr[d] = 1'b0;
        if (m_net[d] > 0) m_net[d]--;
        if (m_hold[d]) begin
          if (IORQ_N) m_hold[d] = 1'b0;
        end else if (m_age[d] == 0) begin
          if (acc && (p == 2'b01 || p == 2'b00)) begin
            m_age[d]  = 1;
            m_port[d] = p;
            m_bd[d]   = BD;
          end
        end else if (m_age[d] == 1) begin
          m_age[d] = (acc && p == m_port[d] && BD == m_bd[d]) ? 2 : 0;
        end else if (m_age[d] < wait_of(d) + 2) begin
          m_age[d] = IORQ_N ? 0 : m_age[d] + 1;
        end else begin
          commit = 1'b1;
        end
        if (commit) begin
          m_age[d]  = 0;
          m_hold[d] = 1'b1;
          if (m_port[d] == 2'b01) begin
            m_map[d] = m_bd[d];
            m_wr[d]  = 1'b1;
          end else begin
            m_spin[d] = !m_bd[d][1];
            if (m_bd[d][0]) m_net[d] = 8;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iorq_n, input logic n_bwr,
                               input logic [1:0] ba, input logic [3:0] bd);
    @(negedge B_PHI);
    IORQ_N     = iorq_n;
    N_BWR      = n_bwr;
    {BA7, BA6} = ba;
    BD         = bd;
  endtask

  task automatic ioCycle(input logic [1:0] ba, input logic [3:0] bd, input logic wr,
                         input int low_n, input int gap_n);
    for (int i = 0; i < low_n; i++) applyStimulus(1'b0, !wr, ba, bd);
    for (int i = 0; i < gap_n; i++) applyStimulus(1'b1, 1'b1, ba, bd);
  endtask

  task automatic checkResetValues(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_map%0d", tag, d), 8'(map_reg[d]), 8'h00);
      checkOutput($sformatf("%s_wr%0d", tag, d), 8'(map_wr[d]), 8'h00);
      checkOutput($sformatf("%s_spin%0d", tag, d), 8'(spindis_n[d]), 8'h01);
      checkOutput($sformatf("%s_net%0d", tag, d), 8'(netrst_n[d]), 8'h01);
      checkOutput($sformatf("%s_wait%0d", tag, d), 8'(io_wait_n[d]), 8'h01);
      checkOutput($sformatf("%s_busy%0d", tag, d), 8'(busy[d]), 8'h00);
    end
  endtask

  // Reset is raised just after a falling edge so the outputs must clear
  // before any rising edge occurs.
  task automatic resetPulse();
    @(negedge B_PHI);
    #1 RST = 1'b1;
    #1 checkResetValues("async_rst");
    @(negedge B_PHI);
    RST = 1'b0;
  endtask

  initial begin
    int wr0, wr1, nt0, nt1, wt0, wt1;

    fork
      forever begin
        @(posedge B_PHI);
        #2;
        if (chk_en) begin
          for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("MAP_REG%0d", d), 8'(map_reg[d]), 8'(m_map[d]));
            checkOutput($sformatf("MAP_WR%0d", d), 8'(map_wr[d]), 8'(m_wr[d]));
            checkOutput($sformatf("SPINDIS_N%0d", d), 8'(spindis_n[d]), 8'(m_spin[d]));
            checkOutput($sformatf("NETRST_N%0d", d), 8'(netrst_n[d]), 8'(m_net[d] == 0));
            checkOutput($sformatf("IO_WAIT_N%0d", d), 8'(io_wait_n[d]),
                        8'(!(m_age[d] >= 2 && m_age[d] < wait_of(d) + 2)));
            checkOutput($sformatf("BUSY%0d", d), 8'(busy[d]), 8'(m_age[d] != 0 || m_hold[d]));
            if (map_wr[d] === 1'b1) n_wr[d]++;
            if (netrst_n[d] === 1'b0) n_net[d]++;
            if (io_wait_n[d] === 1'b0) n_wait[d]++;
          end
        end
      end
    join_none

    IORQ_N = 1'b0; N_BWR = 1'b0; {BA7, BA6} = 2'b01; BD = 4'h5;
    #1 RST = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge B_PHI);
    checkResetValues("rst_hold");
    RST = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'b01, 4'h5);
    checkOutput("rel_map0", 8'(map_reg[0]), 8'h00);
    checkOutput("rel_wr_count", 8'(n_wr[0] + n_wr[1]), 8'h00);

    wr0 = n_wr[0]; wt0 = n_wait[0]; wt1 = n_wait[1];
    ioCycle(2'b01, 4'hA, 1'b1, 3, 3);
    checkOutput("mapA_reg0", 8'(map_reg[0]), 8'h0A);
    checkOutput("mapA_wr0", 8'(n_wr[0] - wr0), 8'h01);
    checkOutput("mapA_wait0", 8'(n_wait[0] - wt0), 8'h01);
    checkOutput("mapA_busy0", 8'(busy[0]), 8'h00);
    checkOutput("abort_reg1", 8'(map_reg[1]), 8'h00);
    checkOutput("abort_wait1", 8'(n_wait[1] - wt1), 8'h02);

    wr0 = n_wr[0]; wr1 = n_wr[1];
    for (int i = 0; i < 16; i++) begin
      ioCycle(2'b01, 4'(i), 1'b1, 8, 2);
      checkOutput($sformatf("sweep_reg0_%0d", i), 8'(map_reg[0]), 8'(i));
      checkOutput($sformatf("sweep_reg1_%0d", i), 8'(map_reg[1]), 8'(i));
    end
    checkOutput("sweep_wr0", 8'(n_wr[0] - wr0), 8'd16);
    checkOutput("sweep_wr1", 8'(n_wr[1] - wr1), 8'd16);

    wr0 = n_wr[0]; wr1 = n_wr[1];
    for (int i = 0; i < 16; i++) ioCycle(2'b10, 4'(i), 1'b1, 8, 2);
    checkOutput("ign_reg0", 8'(map_reg[0]), 8'h0F);
    checkOutput("ign_wr", 8'(n_wr[0] - wr0 + n_wr[1] - wr1), 8'h00);

    nt0 = n_net[0]; nt1 = n_net[1];
    ioCycle(2'b00, 4'b0011, 1'b1, 8, 12);
    checkOutput("ctrl_spin0", 8'(spindis_n[0]), 8'h00);
    checkOutput("ctrl_net0", 8'(n_net[0] - nt0), 8'd8);
    checkOutput("ctrl_net1", 8'(n_net[1] - nt1), 8'd8);

    nt0 = n_net[0]; nt1 = n_net[1];
    ioCycle(2'b00, 4'b0011, 1'b1, 4, 1);
    ioCycle(2'b00, 4'b0001, 1'b1, 8, 14);
    checkOutput("retrig_spin0", 8'(spindis_n[0]), 8'h01);
    checkOutput("retrig_net0", 8'(n_net[0] - nt0), 8'd13);
    checkOutput("retrig_net1", 8'(n_net[1] - nt1), 8'd8);

    wr0 = n_wr[0]; wr1 = n_wr[1];
    ioCycle(2'b01, 4'h2, 1'b1, 1, 3);
    applyStimulus(1'b0, 1'b0, 2'b01, 4'h6);
    applyStimulus(1'b0, 1'b0, 2'b01, 4'h7);
    ioCycle(2'b01, 4'h7, 1'b1, 0, 3);
    checkOutput("glitch_wr", 8'(n_wr[0] - wr0 + n_wr[1] - wr1), 8'h00);
    checkOutput("glitch_reg0", 8'(map_reg[0]), 8'h0F);
    checkOutput("glitch_busy0", 8'(busy[0]), 8'h00);

    wr0 = n_wr[0]; wt0 = n_wait[0]; wt1 = n_wait[1];
    ioCycle(2'b01, 4'h9, 1'b0, 8, 3);
    checkOutput("read_wait", 8'(n_wait[0] - wt0 + n_wait[1] - wt1), 8'h00);
    checkOutput("read_wr0", 8'(n_wr[0] - wr0), 8'h00);

    wt1 = n_wait[1];
    ioCycle(2'b01, 4'h3, 1'b1, 4, 3);
    checkOutput("abort4_reg0", 8'(map_reg[0]), 8'h03);
    checkOutput("abort4_reg1", 8'(map_reg[1]), 8'h0F);
    checkOutput("abort4_wait1", 8'(n_wait[1] - wt1), 8'h03);

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 39) == 0) resetPulse();
      ioCycle(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), $urandom_range(1, 10), $urandom_range(0, 3));
    end
    ioCycle(2'b00, 4'h0, 1'b0, 0, 12);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
